noc_flit_injector: RTL and testbench

- Injection stage between a node's processing element and the router local port (port 5).
- Accepts 16-bit payloads plus destination coordinates from the PE and packs them into 20-bit flits.
- Buffers the flits and drives the router's in5/vi5 inputs under credit-based flow control, using the credit the router returns on co5.
- Decouples PE issue rate from router back-pressure.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/noc_sync_fifo.sv | 40 ++++
 rtl/noc_flit_injector.sv | 77 +++++++
 tb/tb_noc_flit_injector.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: flit layout shared by the injector, router and ejection blocks.
package noc_pkg;
    localparam int FLIT_W = 20;
    localparam int DATA_W = 16;
    localparam int DST_CLUSTER_HI = 19;
    localparam int DST_CLUSTER_LO = 18;
    localparam int DST_LOCAL_HI = 17;
    localparam int DST_LOCAL_LO = 16;

    typedef struct packed {
        logic [1:0] dst_cluster;
        logic [1:0] dst_local;
        logic [DATA_W-1:0] data;
    } flit_t;

    function automatic flit_t pack_flit(input logic [1:0] cluster, input logic [1:0] lcl,
                                        input logic [DATA_W-1:0] data);
        logic [FLIT_W-1:0] f;
        f[DST_CLUSTER_HI:DST_CLUSTER_LO] = cluster;
        f[DST_LOCAL_HI:DST_LOCAL_LO] = lcl;
        f[DATA_W-1:0] = data;
        return flit_t'(f);
    endfunction
endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: synchronous FIFO without fall-through; pushes when full and pops when empty are dropped.
module noc_sync_fifo #(
    parameter int W = 20,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr] <= din;
                wr <= wr + 1'b1;
            end
            if (do_pop) rd <= rd + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/noc_flit_injector.sv
// noc_flit_injector: packs PE payloads into flits and injects them into router port 5 under credit flow control.
// Define NOC_INJ_STATS_EN to add the stat_sent/stat_stall counters.
module noc_flit_injector
    import noc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ROUTER_BUF_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [DATA_W-1:0]                     pe_data,
    input  logic [1:0]                            pe_dst_cluster,
    input  logic [1:0]                            pe_dst_local,
    input  logic                                  pe_valid,
    output logic                                  pe_ready,
    output logic [FLIT_W-1:0]                     inject,
    output logic                                  inject_valid,
    input  logic                                  credit_in,
    output logic [$clog2(ROUTER_BUF_DEPTH+1)-1:0] credit_cnt,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
    output logic                                  credit_err
`ifdef NOC_INJ_STATS_EN
    ,
    output logic [15:0]                           stat_sent,
    output logic [15:0]                           stat_stall
`endif
);
    localparam int CW = $clog2(ROUTER_BUF_DEPTH+1);
    localparam logic [CW-1:0] CMAX = CW'(ROUTER_BUF_DEPTH);
    logic full, empty, push, pop;
    logic [FLIT_W-1:0] head;
    assign pe_ready = !rst && !full;
    assign push = pe_valid && pe_ready;
    assign pop = !rst && !empty && credit_cnt != '0;

    noc_sync_fifo #(.W(FLIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .din(pack_flit(pe_dst_cluster, pe_dst_local, pe_data)),
        .pop(pop),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            inject <= '0;
            inject_valid <= 1'b0;
            credit_cnt <= CMAX;
            credit_err <= 1'b0;
        end else begin
            inject_valid <= pop;
            if (pop) inject <= head;
            if (pop && !credit_in) credit_cnt <= credit_cnt - 1'b1;
            else if (!pop && credit_in) begin
                // A credit with nothing outstanding is a router protocol error; hold at max.
                if (credit_cnt == CMAX) credit_err <= 1'b1;
                else credit_cnt <= credit_cnt + 1'b1;
            end
        end
    end

`ifdef NOC_INJ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_sent <= '0;
            stat_stall <= '0;
        end else begin
            stat_sent <= stat_sent + 16'(inject_valid);
            stat_stall <= stat_stall + 16'(!empty && credit_cnt == '0);
        end
    end
`endif
endmodule

// File: tb/tb_noc_flit_injector.sv
// tb_noc_flit_injector: directed test-plan steps plus random traffic, checked against a queue-based reference model.
module tb_noc_flit_injector;
    localparam int FD = 4;
    localparam int RBD = 4;

    logic clk, rst, pe_valid, pe_ready, inject_valid, credit_in, credit_err;
    logic [15:0] pe_data;
    logic [1:0] pe_dst_cluster, pe_dst_local;
    logic [19:0] inject;
    logic [$clog2(RBD+1)-1:0] credit_cnt;
    logic [$clog2(FD+1)-1:0] fifo_count;
`ifdef NOC_INJ_STATS_EN
    logic [15:0] stat_sent, stat_stall;
`endif

    noc_flit_injector #(.FIFO_DEPTH(FD), .ROUTER_BUF_DEPTH(RBD)) dut (
        .clk(clk),
        .rst(rst),
        .pe_data(pe_data),
        .pe_dst_cluster(pe_dst_cluster),
        .pe_dst_local(pe_dst_local),
        .pe_valid(pe_valid),
        .pe_ready(pe_ready),
        .inject(inject),
        .inject_valid(inject_valid),
        .credit_in(credit_in),
        .credit_cnt(credit_cnt),
        .fifo_count(fifo_count),
        .credit_err(credit_err)
`ifdef NOC_INJ_STATS_EN
        ,
        .stat_sent(stat_sent),
        .stat_stall(stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [19:0] m_q [$];
    int m_cnt;
    logic m_err, m_vld, saw_1234;
    logic [19:0] m_inj;
    logic [15:0] m_sent, m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic r, input logic v, input logic [15:0] d, input logic [1:0] c,
                        input logic [1:0] l, input logic ci);
        logic do_push, do_pop;
        rst = r; pe_valid = v; pe_data = d; pe_dst_cluster = c; pe_dst_local = l; credit_in = ci;
        #1;
        chk("pe_ready", 32'(pe_ready), 32'(!r && m_q.size() < FD));
        @(posedge clk);
        if (r) begin
            m_q.delete(); m_cnt = RBD; m_err = 0; m_inj = '0; m_vld = 0; m_sent = '0; m_stall = '0;
        end else begin
            m_sent = m_sent + 16'(m_vld);
            if (m_q.size() > 0 && m_cnt == 0) m_stall = m_stall + 16'd1;
            do_pop = m_q.size() > 0 && m_cnt > 0;
            do_push = v && m_q.size() < FD;
            m_vld = do_pop;
            if (do_pop) m_inj = m_q.pop_front();
            m_cnt = m_cnt + int'(ci) - int'(do_pop);
            if (m_cnt > RBD) begin m_cnt = RBD; m_err = 1; end
            if (do_push) m_q.push_back({c, l, d});
        end
        #1;
        chk("inject_valid", 32'(inject_valid), 32'(m_vld));
        chk("inject", 32'(inject), 32'(m_inj));
        chk("credit_cnt", 32'(credit_cnt), 32'(m_cnt));
        chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        chk("credit_err", 32'(credit_err), 32'(m_err));
`ifdef NOC_INJ_STATS_EN
        chk("stat_sent", 32'(stat_sent), 32'(m_sent));
        chk("stat_stall", 32'(stat_stall), 32'(m_stall));
`endif
        if (inject_valid && inject[15:0] == 16'h1234) saw_1234 = 1;
    endtask

    task automatic idle(input logic ci);
        tick(0, 0, 16'h0, 2'd0, 2'd0, ci);
    endtask

    task automatic push(input logic [15:0] d, input logic ci);
        tick(0, 1, d, d[1:0], d[3:2], ci);
    endtask

    task automatic settle();
        for (int i = 0; i < 40 && (m_q.size() > 0 || m_cnt < RBD); i++) idle(m_cnt < RBD);
    endtask

    initial begin
        saw_1234 = 0;
        m_q.delete(); m_cnt = RBD; m_err = 0; m_inj = '0; m_vld = 0; m_sent = '0; m_stall = '0;
        rst = 1; pe_valid = 0; pe_data = '0; pe_dst_cluster = '0; pe_dst_local = '0; credit_in = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) tick(1, 0, 16'h0, 2'd0, 2'd0, 1);
        // single push, two edges of latency
        idle(0);
        tick(0, 1, 16'hA5A5, 2'd2, 2'd1, 0);
        idle(0);
        chk("first_flit", 32'(inject), 32'h9A5A5);
        chk("first_credit", 32'(credit_cnt), 32'd3);
        settle();
        // credit exhaustion
        for (int i = 0; i < 6; i++) push(16'h0100 + 16'(i), 0);
        idle(0);
        chk("exhaust_count", 32'(fifo_count), 32'd2);
        chk("exhaust_credit", 32'(credit_cnt), 32'd0);
        idle(1);
        idle(0);
        chk("fifth_sent", 32'(inject), 32'(16'h0104) | (32'(4'h4 >> 2) << 16) | 32'h0);
        settle();
        // full FIFO with credits withheld
        for (int i = 0; i < 4; i++) push(16'h0200 + 16'(i), 0);
        for (int i = 0; i < 4; i++) push(16'h0300 + 16'(i), 0);
        chk("full_ready", 32'(pe_ready), 32'd0);
        push(16'h1234, 0);
        settle();
        chk("no_1234", 32'(saw_1234), 32'd0);
        // simultaneous pop and credit at cnt 2
        push(16'h0400, 0); idle(0); push(16'h0401, 0); idle(0);
        push(16'h0402, 0); idle(1);
        chk("pop_and_credit", 32'(credit_cnt), 32'd2);
        settle();
        // spurious credit
        idle(1);
        chk("spurious_cnt", 32'(credit_cnt), 32'd4);
        chk("spurious_err", 32'(credit_err), 32'd1);
        for (int i = 0; i < 3; i++) idle(0);
        // mid-operation reset with 3 buffered and one credit
        for (int i = 0; i < 7; i++) push(16'h0500 + 16'(i), 0);
        idle(1);
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        chk("pre_rst_cnt", 32'(credit_cnt), 32'd1);
        tick(1, 1, 16'h0600, 2'd1, 2'd1, 1);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_cnt", 32'(credit_cnt), 32'd4);
        chk("rst_valid", 32'(inject_valid), 32'd0);
        chk("rst_err", 32'(credit_err), 32'd0);
`ifdef NOC_INJ_STATS_EN
        chk("rst_sent", 32'(stat_sent), 32'd0);
        chk("rst_stall", 32'(stat_stall), 32'd0);
`endif
        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic r, v, ci;
            r = $urandom_range(0, 149) == 0;
            v = $urandom_range(0, 2) != 0;
            ci = m_cnt < RBD ? $urandom_range(0, 2) == 0 : $urandom_range(0, 59) == 0;
            tick(r, v, 16'($urandom), 2'($urandom), 2'($urandom), ci);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
